alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//   Issue/retire stage that wraps the 4-bit combinational ALU. Accepts ALU ops on a
//   valid/ready input and registers them onto the ALU operand/ctrl pins (S1).
//   Captures the ALU result, carry and overflow into an output register (S2), which
//   it presents on a valid/ready output. Keeps a sticky overflow flag and a retired-op counter.
// PARAMETERS
//   W      4  operand/result width; must equal the ALU width (4)
//   CNT_W  8  width of op_cnt
// PORTS
//   clk         in   1      single clock, all state on rising edge
//   rst         in   1      asynchronous, active-high reset
//   in_valid    in   1      op offered
//   in_ready    out  1      stage can accept op this cycle
//   in_ctrl     in   3      ALU opcode (000 add .. 111 eq)
//   in_a        in   W      operand a
//   in_b        in   W      operand b
//   alu_a       out  W      to ALU a (S1 register)
//   alu_b       out  W      to ALU b (S1 register)
//   alu_ctrl    out  3      to ALU ctrl (S1 register)
//   alu_res     in   W      from ALU res
//   alu_car     in   1      from ALU car
//   alu_of      in   1      from ALU of
//   out_valid   out  1      result held in S2
//   out_ready   in   1      consumer takes result
//   out_res     out  W      captured result
//   out_car     out  1      captured carry
//   out_of      out  1      captured overflow
//   out_ctrl    out  3      opcode of the captured result
//   clr_sticky  in   1      clears sticky_of
//   sticky_of   out  1      set by any captured overflow
//   op_cnt      out  CNT_W  number of retired ops (out handshakes)
// BEHAVIOUR
// - Reset (async, immediate): s1_valid=0, out_valid=0, alu_a/alu_b/alu_ctrl=0.
//   out_res/out_car/out_of/out_ctrl=0, sticky_of=0, op_cnt=0; in_ready reads 1.
// - Reset mid-operation discards in-flight ops; no out handshake occurs for them.
// - s2_free  = !out_valid || out_ready.
// - s1_adv   = s1_valid && s2_free.
// - in_ready = !s1_valid || s1_adv.
//   No combinational path from in_valid to in_ready; out_ready->in_ready is allowed.
// - Accept (in_valid && in_ready): S1 loads a/b/ctrl and sets s1_valid.
//   If S1 advances without a new accept, s1_valid clears and alu_* hold their last value.
// - s1_adv: S2 loads the live alu_res/alu_car/alu_of plus alu_ctrl, and sets out_valid.
//   Otherwise out_valid clears on an out handshake.
// - Latency: accepted at edge k -> out_valid high after edge k+1 when S2 is free.
//   Throughput is 1 op/clk; accept, advance and retire can all happen in the same cycle.
// - Backpressure: while out_valid && !out_ready, all out_* stay stable.
//   S1 holds one op; in_ready=0 when both S1 and S2 are full.
// - Logic/compare ops (ctrl >= 3'b010): out_car and out_of are forced to 0 at capture,
//   regardless of the ALU pins.
// - sticky_of: set at S2 load when the captured (masked) of=1.
//   clr_sticky clears it. Set and clear in the same cycle -> set wins (stays 1).
// - op_cnt: increments on out_valid && out_ready and wraps from 2^CNT_W-1 to 0.
// - Ordering: results retire strictly in acceptance order; no op is dropped or duplicated.
// STRUCTURE
// - Package alu_pkg:
//   localparam ALU_W=4.
//   typedef enum logic[2:0] alu_op_e {OP_ADD=000, OP_SUB=001, OP_NOT=010, OP_AND=011,
//     OP_OR=100, OP_XOR=101, OP_LT=110, OP_EQ=111}.
//   typedef struct alu_req_t {a, b, ctrl}.
// - Sub-module alu_pipe_slice: parameterised (DW) valid/ready register slice with async
//   active-high rst, instantiated for S1 (DW=2W+3) and S2 (DW=W+5).
// - Top level adds car/of masking, sticky_of and op_cnt.
// TESTING (bench instantiates the real ALU behind this stage)
// 1. Assert rst with 2 ops in flight -> out_valid=0, in_ready=1, op_cnt=0 and sticky_of=0
//    in the same cycle; no result appears afterwards.
// 2. ADD a=0111 b=0001, out_ready=1 -> out_res=1000, car=0, of=1, out_ctrl=000
//    one edge after S1 load; sticky_of=1.
// 3. out_ready=0; offer XOR 1100^1010, AND 1111&0011, OR 0001|0100 back to back.
//    -> in_ready drops after 2 accepts; out_res=0110 held stable.
//    Release -> 0110, 0011, 0101 retire in order; op_cnt=3.
// 4. Force ALU car=1/of=1 on AND (ctrl=011) -> out_car=0, out_of=0, sticky_of unchanged.
// 5. 8 ops with in_valid and out_ready held high -> 8 results on 8 consecutive cycles.
//    With CNT_W=3, op_cnt wraps 7->0.
// 6. clr_sticky asserted in the cycle S2 captures of=1 -> sticky_of=1.
//    clr_sticky alone on the next cycle -> sticky_of=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage.
// Defines the ALU width, opcode enum and the S1 request bundle.
package alu_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_NOT = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_LT  = 3'b110,
    OP_EQ  = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    alu_op_e          ctrl;
  } alu_req_t;

endpackage

// File: rtl/alu_pipe_slice.sv
// One-entry valid/ready register slice, async active-high reset.
// Ports: in_valid/in_ready/in_data -> out_valid/out_ready/out_data.
module alu_pipe_slice #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  // Full throughput: a full slice still accepts when it drains.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/retire stage around the 4-bit ALU: S1 drives the ALU pins,
// S2 captures result/flags; sticky overflow and retired-op counter.
// Ports: in_* op input, alu_* ALU pins, out_* result, clr_sticky,
// sticky_of, op_cnt.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_ctrl,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [W-1:0]     alu_res,
  input  logic             alu_car,
  input  logic             alu_of,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_res,
  output logic             out_car,
  output logic             out_of,
  output logic [2:0]       out_ctrl,
  input  logic             clr_sticky,
  output logic             sticky_of,
  output logic [CNT_W-1:0] op_cnt
);

  localparam int S1_W = 2*W + 3;
  localparam int S2_W = W + 5;

  alu_req_t        req_d;
  alu_req_t        req_q;
  logic            s1_valid;
  logic            s2_free;
  logic            s1_adv;
  logic            logic_op;
  logic            car_m;
  logic            of_m;
  logic [S2_W-1:0] s2_d;
  logic [S2_W-1:0] s2_q;

  assign req_d.a    = in_a;
  assign req_d.b    = in_b;
  assign req_d.ctrl = alu_op_e'(in_ctrl);

  alu_pipe_slice #(.DW(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (req_d),
    .out_valid (s1_valid),
    .out_ready (s2_free),
    .out_data  (req_q)
  );

  assign alu_a    = req_q.a;
  assign alu_b    = req_q.b;
  assign alu_ctrl = req_q.ctrl;

  // Carry/overflow only mean something for add/sub.
  assign logic_op = alu_ctrl[2] | alu_ctrl[1];
  assign car_m    = alu_car & ~logic_op;
  assign of_m     = alu_of & ~logic_op;
  assign s2_d     = {alu_res, car_m, of_m, alu_ctrl};

  alu_pipe_slice #(.DW(S2_W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_free),
    .in_data   (s2_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

  assign {out_res, out_car, out_of, out_ctrl} = s2_q;

  assign s1_adv = s1_valid && s2_free;

  // A capture of overflow beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_of <= 1'b0;
    end else if (s1_adv && of_m) begin
      sticky_of <= 1'b1;
    end else if (clr_sticky) begin
      sticky_of <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_cnt <= '0;
    end else if (out_valid && out_ready) begin
      op_cnt <= op_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage with a behavioural 4-bit ALU behind it.
// Scoreboard queue: push on accept, pop on retire.
module tb_alu_issue_stage;
  import alu_pkg::*;

  typedef struct packed {
    logic [3:0] res;
    logic       car;
    logic       of;
    logic [2:0] ctrl;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_ctrl = '0;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_ctrl;
  logic [3:0] alu_res;
  logic       alu_car;
  logic       alu_of;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_res;
  logic       out_car;
  logic       out_of;
  logic [2:0] out_ctrl;
  logic       clr_sticky = 1'b0;
  logic       sticky_of;
  logic [2:0] op_cnt;
  logic       force_co = 1'b0;

  res_t       cur;
  res_t       q[$];
  res_t       exp_r;
  logic [2:0] exp_cnt = '0;
  logic       prev_hold = 1'b0;
  logic [9:0] prev_out = '0;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.W(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_a       (in_a),
    .in_b       (in_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_res    (alu_res),
    .alu_car    (alu_car),
    .alu_of     (alu_of),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .out_car    (out_car),
    .out_of     (out_of),
    .out_ctrl   (out_ctrl),
    .clr_sticky (clr_sticky),
    .sticky_of  (sticky_of),
    .op_cnt     (op_cnt)
  );

  function automatic logic [5:0] alu_f(
    input logic [2:0] c,
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [4:0] t;
    logic [3:0] r;
    logic       cy;
    logic       ov;
    t  = '0;
    r  = '0;
    cy = 1'b0;
    ov = 1'b0;
    case (c)
      3'd0: begin
        t  = {1'b0, a} + {1'b0, b};
        r  = t[3:0];
        cy = t[4];
        ov = (a[3] == b[3]) && (r[3] != a[3]);
      end
      3'd1: begin
        t  = {1'b0, a} - {1'b0, b};
        r  = t[3:0];
        cy = t[4];
        ov = (a[3] != b[3]) && (r[3] != a[3]);
      end
      3'd2: r = ~a;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = {3'b000, a < b};
      default: r = {3'b000, a == b};
    endcase
    return {cy, ov, r};
  endfunction

  always_comb begin
    {alu_car, alu_of, alu_res} = alu_f(alu_ctrl, alu_a, alu_b);
    if (force_co) begin
      alu_car = 1'b1;
      alu_of  = 1'b1;
    end
  end

  assign cur = {out_res, out_car, out_of, out_ctrl};

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic res_t model(
    input logic [2:0] c,
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [5:0] e;
    res_t       r;
    e      = alu_f(c, a, b);
    r.res  = e[3:0];
    r.car  = (c >= 3'd2) ? 1'b0 : e[5];
    r.of   = (c >= 3'd2) ? 1'b0 : e[4];
    r.ctrl = c;
    return r;
  endfunction

  // Scoreboard and hold checks, mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_cnt   = '0;
      prev_hold = 1'b0;
    end else begin
      chk("op_cnt", op_cnt, exp_cnt);
      if (prev_hold) chk("hold", {out_valid, cur}, prev_out);
      prev_hold = out_valid && !out_ready;
      prev_out  = {out_valid, cur};
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious", 1, 0);
        end else begin
          exp_r = q.pop_front();
          chk("result", cur, exp_r);
        end
        exp_cnt++;
      end
      if (in_valid && in_ready)
        q.push_back(model(in_ctrl, in_a, in_b));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [2:0] c,
    input logic [3:0] a,
    input logic [3:0] b
  );
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_ctrl  = c;
    in_a     = a;
    in_b     = b;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    int run;
    int maxr;
    #2;
    chk("rst_state",
        {out_valid, in_ready, alu_a, alu_b, alu_ctrl,
         cur, sticky_of, op_cnt},
        {1'b0, 1'b1, 4'h0, 4'h0, 3'h0, 9'h0, 1'b0, 3'h0});
    tick();
    tick();
    rst = 1'b0;

    // reset with two ops in flight
    out_ready = 1'b0;
    send(3'd0, 4'b0111, 4'b0001);
    send(3'd1, 4'd5, 4'd3);
    #2 rst = 1'b1;
    #1;
    chk("rst_ov", out_valid, 0);
    chk("rst_ir", in_ready, 1);
    chk("rst_cnt", op_cnt, 0);
    chk("rst_sticky", sticky_of, 0);
    tick();
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("no_ghost", out_valid, 0);

    // add with overflow, latency
    send(3'd0, 4'b0111, 4'b0001);
    chk("lat_early", out_valid, 0);
    tick();
    chk("lat_ov", out_valid, 1);
    chk("add_res", cur, {4'b1000, 1'b0, 1'b1, 3'b000});
    chk("add_sticky", sticky_of, 1);
    tick();

    // backpressure
    out_ready = 1'b0;
    send(3'd5, 4'b1100, 4'b1010);
    send(3'd3, 4'b1111, 4'b0011);
    in_valid = 1'b1;
    in_ctrl  = 3'd4;
    in_a     = 4'b0001;
    in_b     = 4'b0100;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ir", in_ready, 0);
      chk("bp_res", out_res, 4'b0110);
      tick();
    end
    out_ready = 1'b1;
    send(3'd4, 4'b0001, 4'b0100);
    repeat (3) tick();
    chk("bp_cnt", op_cnt, 4);
    chk("bp_drain", out_valid, 0);

    // flag masking on logic op
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("clr", sticky_of, 0);
    force_co = 1'b1;
    send(3'd3, 4'b1100, 4'b1010);
    tick();
    chk("mask", {out_valid, out_res, out_car, out_of},
        {1'b1, 4'b1000, 1'b0, 1'b0});
    chk("mask_sticky", sticky_of, 0);
    force_co = 1'b0;
    tick();

    // streaming and counter wrap
    run  = 0;
    maxr = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(3'(i), 4'(i + 3), 4'(3 * i));
      end
      begin
        repeat (14) begin
          @(negedge clk);
          if (out_valid && out_ready) run++;
          else run = 0;
          if (run > maxr) maxr = run;
        end
      end
    join
    chk("stream8", maxr, 8);
    chk("wrap", op_cnt, 5);

    // set beats clear
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    send(3'd0, 4'b0111, 4'b0001);
    clr_sticky = 1'b1;
    tick();
    chk("set_wins", sticky_of, 1);
    tick();
    chk("clr_alone", sticky_of, 0);
    clr_sticky = 1'b0;
    repeat (3) tick();
    chk("sb_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
